// File: rtl/alzette_inv_seq.sv
// rtl/alzette_inv_seq.sv - multi-cycle inverse Alzette ARX-box with valid/ready handshake
module alzette_inv_seq #(
  parameter int UNROLL = 1
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_x,
  input  logic [31:0] in_y,
  input  logic [31:0] in_c,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_x,
  output logic [31:0] out_y
);

  // Only divisors of the four-round schedule keep rnd landing exactly on 4.
  generate
    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4)) begin : g_bad_unroll
      $error("alzette_inv_seq: UNROLL must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_rnd;
  logic [2:0]  w_rnd_nxt;
  logic [31:0] r_x;
  logic [31:0] r_y;
  logic [31:0] r_c;
  logic [31:0] w_x_nxt;
  logic [31:0] w_y_nxt;

  function automatic logic [31:0] f_ror(input logic [31:0] v, input logic [4:0] n);
    return (v >> n) | (v << (6'd32 - {1'b0, n}));
  endfunction

  // Inverse round r undoes forward round 3-r; a rotate of 0 degenerates to a plain subtract.
  function automatic logic [63:0] f_inv_round(input logic [31:0] x, input logic [31:0] y,
                                              input logic [31:0] c, input logic [1:0] r);
    logic [4:0]  a;
    logic [4:0]  b;
    logic [31:0] x1;
    logic [31:0] yn;
    logic [31:0] xn;
    case (r)
      2'd0:    begin a = 5'd16; b = 5'd24; end
      2'd1:    begin a = 5'd31; b = 5'd0;  end
      2'd2:    begin a = 5'd17; b = 5'd17; end
      default: begin a = 5'd24; b = 5'd31; end
    endcase
    x1 = x ^ c;
    yn = y ^ f_ror(x1, a);
    xn = x1 - f_ror(yn, b);
    return {xn, yn};
  endfunction

  assign w_rnd_nxt = r_rnd + 3'(UNROLL);

  // Chain UNROLL inverse rounds starting at the current round index.
  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    for (int k = 0; k < UNROLL; k++) begin
      {w_x_nxt, w_y_nxt} = f_inv_round(w_x_nxt, w_y_nxt, r_c, r_rnd[1:0] + 2'(k));
    end
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: accept when idle, finish when the last round lands, release on out_ready.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (in_valid)              w_state_nxt = S_RUN;
      S_RUN:  if (w_rnd_nxt == 3'd4)     w_state_nxt = S_DONE;
      S_DONE: if (out_ready)             w_state_nxt = S_IDLE;
      default:                           w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded straight from the state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE:  in_ready  = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: begin end
    endcase
  end

  // Operand latch on accept, round update while running, hold otherwise.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_x   <= 32'd0;
      r_y   <= 32'd0;
      r_c   <= 32'd0;
      r_rnd <= 3'd0;
    end else if (r_state == S_IDLE && in_valid) begin
      r_x   <= in_x;
      r_y   <= in_y;
      r_c   <= in_c;
      r_rnd <= 3'd0;
    end else if (r_state == S_RUN) begin
      r_x   <= w_x_nxt;
      r_y   <= w_y_nxt;
      r_rnd <= w_rnd_nxt;
    end
  end

  assign out_x = r_x;
  assign out_y = r_y;

endmodule

// File: tb/tb_alzette_inv_seq.sv
// tb/tb_alzette_inv_seq.sv - directed and round-trip bench for alzette_inv_seq (UNROLL 1, 2, 4)
`timescale 1ns/1ps
module tb_alzette_inv_seq;

  logic        g_clk;
  logic        g_resetn;
  logic [2:0]  in_valid;
  logic [2:0]  in_ready;
  logic [2:0]  out_valid;
  logic [31:0] in_x;
  logic [31:0] in_y;
  logic [31:0] in_c;
  logic        out_ready;
  logic [31:0] ox [3];
  logic [31:0] oy [3];

  int checks;
  int fails;

  alzette_inv_seq #(.UNROLL(1)) u_dut1 (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_x(in_x), .in_y(in_y), .in_c(in_c),
    .out_valid(out_valid[0]), .out_ready(out_ready),
    .out_x(ox[0]), .out_y(oy[0])
  );

  alzette_inv_seq #(.UNROLL(2)) u_dut2 (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_x(in_x), .in_y(in_y), .in_c(in_c),
    .out_valid(out_valid[1]), .out_ready(out_ready),
    .out_x(ox[1]), .out_y(oy[1])
  );

  alzette_inv_seq #(.UNROLL(4)) u_dut4 (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_x(in_x), .in_y(in_y), .in_c(in_c),
    .out_valid(out_valid[2]), .out_ready(out_ready),
    .out_x(ox[2]), .out_y(oy[2])
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  function automatic logic [31:0] ror(input logic [31:0] v, input int n);
    return (v >> n) | (v << (32 - n));
  endfunction

  // Forward Alzette, used only to manufacture ciphertext inputs.
  function automatic logic [63:0] fwd(input logic [31:0] xi, input logic [31:0] yi, input logic [31:0] c);
    logic [31:0] x;
    logic [31:0] y;
    x = xi; y = yi;
    x = x + ror(y, 31); y = y ^ ror(x, 24); x = x ^ c;
    x = x + ror(y, 17); y = y ^ ror(x, 17); x = x ^ c;
    x = x + y;          y = y ^ ror(x, 31); x = x ^ c;
    x = x + ror(y, 24); y = y ^ ror(x, 16); x = x ^ c;
    return {x, y};
  endfunction

  // Runs one operation on DUT s; stall = cycles out_ready is held low in DONE.
  task automatic do_op(input int s, input logic [31:0] x, input logic [31:0] y, input logic [31:0] c,
                       input int stall, output logic [31:0] rx, output logic [31:0] ry, output int lat);
    int n;
    n = 0;
    while (!in_ready[s] && n < 50) begin
      @(posedge g_clk); #1; n++;
    end
    checks++;
    if (!in_ready[s]) begin
      fails++;
      $display("FAIL in_ready_timeout dut%0d: got %b expected 1", s, in_ready[s]);
    end
    in_x = x; in_y = y; in_c = c;
    in_valid[s] = 1'b1;
    @(posedge g_clk); #1;
    in_valid[s] = 1'b0;
    in_x = $urandom; in_y = $urandom; in_c = $urandom;
    lat = 0;
    do begin
      out_ready = 1'($urandom_range(0, 1));
      @(posedge g_clk); #1;
      lat++;
    end while (!out_valid[s] && lat < 50);
    out_ready = 1'b0;
    checks++;
    if (!out_valid[s]) begin
      fails++;
      $display("FAIL out_valid_timeout dut%0d: got %b expected 1", s, out_valid[s]);
    end
    repeat (stall) begin
      @(posedge g_clk); #1;
    end
    rx = ox[s];
    ry = oy[s];
    out_ready = 1'b1;
    @(posedge g_clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    g_resetn = 1'b0;
    #2;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (out_valid[s] !== 1'b0) begin fails++; $display("FAIL reset_out_valid dut%0d: got %b expected 0", s, out_valid[s]); end
      checks++;
      if (ox[s] !== 32'd0 || oy[s] !== 32'd0) begin
        fails++; $display("FAIL reset_out_xy dut%0d: got %h/%h expected 0/0", s, ox[s], oy[s]);
      end
    end
    @(posedge g_clk); #1;
    g_resetn = 1'b1;
    @(posedge g_clk); #1;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (in_ready[s] !== 1'b1) begin fails++; $display("FAIL reset_in_ready dut%0d: got %b expected 1", s, in_ready[s]); end
    end
  endtask

  task automatic test_zero;
    logic [31:0] rx, ry;
    int lat;
    do_op(0, 32'd0, 32'd0, 32'd0, 0, rx, ry, lat);
    checks++;
    if (rx !== 32'd0 || ry !== 32'd0) begin fails++; $display("FAIL zero_result: got %h/%h expected 0/0", rx, ry); end
    checks++;
    if (lat !== 4) begin fails++; $display("FAIL zero_latency: got %0d expected 4", lat); end
  endtask

  task automatic test_vector;
    logic [63:0] ct;
    logic [31:0] rx, ry;
    int lat;
    ct = fwd(32'h01234567, 32'h89ABCDEF, 32'hB7E15162);
    do_op(0, ct[63:32], ct[31:0], 32'hB7E15162, 1, rx, ry, lat);
    checks++;
    if (rx !== 32'h01234567) begin fails++; $display("FAIL vector_x: got %h expected 01234567", rx); end
    checks++;
    if (ry !== 32'h89ABCDEF) begin fails++; $display("FAIL vector_y: got %h expected 89abcdef", ry); end
  endtask

  task automatic test_random;
    logic [31:0] x, y, c, rx, ry;
    logic [63:0] ct;
    int lat;
    for (int i = 0; i < 500; i++) begin
      x = $urandom; y = $urandom; c = $urandom;
      ct = fwd(x, y, c);
      do_op(0, ct[63:32], ct[31:0], c, $urandom_range(0, 3), rx, ry, lat);
      checks++;
      if (rx !== x || ry !== y) begin
        fails++; $display("FAIL random_roundtrip #%0d: got %h/%h expected %h/%h", i, rx, ry, x, y);
      end
    end
  endtask

  task automatic test_stall;
    logic [63:0] ct;
    logic [31:0] rx, ry;
    int lat;
    ct = fwd(32'hDEADBEEF, 32'h0BADF00D, 32'h38B4DA56);
    in_x = ct[63:32]; in_y = ct[31:0]; in_c = 32'h38B4DA56;
    in_valid[0] = 1'b1;
    @(posedge g_clk); #1;
    in_valid[0] = 1'b0;
    lat = 0;
    while (!out_valid[0] && lat < 50) begin @(posedge g_clk); #1; lat++; end
    for (int i = 0; i < 10; i++) begin
      in_valid[0] = 1'($urandom_range(0, 1));
      in_x = $urandom; in_y = $urandom; in_c = $urandom;
      @(posedge g_clk); #1;
      checks++;
      if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0) begin
        fails++; $display("FAIL stall_handshake cyc%0d: got v=%b r=%b expected v=1 r=0", i, out_valid[0], in_ready[0]);
      end
      checks++;
      if (ox[0] !== 32'hDEADBEEF || oy[0] !== 32'h0BADF00D) begin
        fails++; $display("FAIL stall_data cyc%0d: got %h/%h expected deadbeef/0badf00d", i, ox[0], oy[0]);
      end
    end
    in_valid[0] = 1'b0;
    out_ready = 1'b1;
    @(posedge g_clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      fails++; $display("FAIL stall_release: got v=%b r=%b expected v=0 r=1", out_valid[0], in_ready[0]);
    end
    ct = fwd(32'h13579BDF, 32'h2468ACE0, 32'h324E7738);
    do_op(0, ct[63:32], ct[31:0], 32'h324E7738, 0, rx, ry, lat);
    checks++;
    if (rx !== 32'h13579BDF || ry !== 32'h2468ACE0) begin
      fails++; $display("FAIL stall_followup: got %h/%h expected 13579bdf/2468ace0", rx, ry);
    end
  endtask

  task automatic test_reset_mid;
    logic [63:0] ct;
    logic [31:0] rx, ry;
    int lat;
    in_x = 32'hFFFFFFFF; in_y = 32'h12345678; in_c = 32'hBB1185EB;
    in_valid[0] = 1'b1;
    @(posedge g_clk); #1;
    in_valid[0] = 1'b0;
    @(posedge g_clk); #1;
    @(posedge g_clk); #1;
    g_resetn = 1'b0;
    #1;
    checks++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      fails++; $display("FAIL midreset_handshake: got v=%b r=%b expected v=0 r=1", out_valid[0], in_ready[0]);
    end
    checks++;
    if (ox[0] !== 32'd0 || oy[0] !== 32'd0) begin
      fails++; $display("FAIL midreset_regs: got %h/%h expected 0/0", ox[0], oy[0]);
    end
    @(posedge g_clk); #1;
    g_resetn = 1'b1;
    @(posedge g_clk); #1;
    ct = fwd(32'h01234567, 32'h89ABCDEF, 32'hB7E15162);
    do_op(0, ct[63:32], ct[31:0], 32'hB7E15162, 0, rx, ry, lat);
    checks++;
    if (rx !== 32'h01234567 || ry !== 32'h89ABCDEF) begin
      fails++; $display("FAIL midreset_followup: got %h/%h expected 01234567/89abcdef", rx, ry);
    end
    checks++;
    if (lat !== 4) begin fails++; $display("FAIL midreset_latency: got %0d expected 4", lat); end
  endtask

  task automatic test_unroll;
    logic [63:0] ct;
    logic [31:0] rx, ry;
    int lat;
    ct = fwd(32'h01234567, 32'h89ABCDEF, 32'hB7E15162);
    for (int s = 1; s < 3; s++) begin
      do_op(s, ct[63:32], ct[31:0], 32'hB7E15162, 2, rx, ry, lat);
      checks++;
      if (rx !== 32'h01234567 || ry !== 32'h89ABCDEF) begin
        fails++; $display("FAIL unroll_result dut%0d: got %h/%h expected 01234567/89abcdef", s, rx, ry);
      end
      checks++;
      if (lat !== (s == 1 ? 2 : 1)) begin
        fails++; $display("FAIL unroll_latency dut%0d: got %0d expected %0d", s, lat, (s == 1 ? 2 : 1));
      end
    end
  endtask

  initial begin
    checks = 0;
    fails = 0;
    in_valid = 3'b000;
    out_ready = 1'b0;
    in_x = 32'd0; in_y = 32'd0; in_c = 32'd0;
    g_resetn = 1'b0;
    test_reset();
    test_zero();
    test_vector();
    test_stall();
    test_reset_mid();
    test_unroll();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
